// File: rtl/ad7671_pkg.sv
// Shared constants, FSM state type and result-address packing for the AD7671 scan sequencer.
package ad7671_pkg;

    localparam int unsigned N_ADC           = 4;
    localparam int unsigned N_CH            = 8;
    localparam int unsigned ADC_W           = 2;
    localparam int unsigned CH_W            = 3;
    localparam int unsigned ADDR_W          = ADC_W + CH_W;
    localparam int unsigned D_W             = 16;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned SETTLE_CYC      = 16;
    localparam int unsigned CNV_LOW_CYC     = 2;
    localparam int unsigned RD_CYC          = 3;
    localparam int unsigned BUSY_TMO        = 255;
    localparam int unsigned BUSY_IGNORE_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT_BUSY,
        ST_READ,
        ST_NEXT
    } state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ADC_W-1:0] adc,
                                                    input logic [CH_W-1:0]  ch);
        return {adc, ch};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; reset clears both stages.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ad7671_scan_sequencer.sv
// Steps the shared analog mux, converts on all AD7671s together, then reads each ADC
// over the shared bus and writes every sample into the result RAM.
module ad7671_scan_sequencer
    import ad7671_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont_en,
    input  logic              clr_err,
    output logic [CH_W-1:0]   mux_sel,
    output logic [N_ADC-1:0]  cnvst_n,
    input  logic [N_ADC-1:0]  busy,
    output logic [N_ADC-1:0]  cs_n,
    output logic              rd_n,
    input  logic [D_W-1:0]    d,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [D_W-1:0]    res_data,
    output logic              scan_act,
    output logic              scan_done,
    output logic              err
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADC_W-1:0]    adc_q, adc_d;
    logic                armed_q, armed_d;
    logic [CH_W-1:0]     ch_d;
    logic [N_ADC-1:0]    busy_s;
    logic                tmo;
    logic [N_ADC-1:0]    cnvst_n_d, cs_n_d;
    logic                rd_n_d, res_we_d, scan_act_d, scan_done_d, err_d;
    logic [ADDR_W-1:0]   res_addr_d;
    logic [D_W-1:0]      res_data_d;

    sync_2ff #(.W(N_ADC)) u_busy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (busy),
        .q     (busy_s)
    );

    // mux_sel doubles as the channel register; it only moves on entry to SETTLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adc_d   = adc_q;
        armed_d = armed_q;
        ch_d    = mux_sel;
        tmo     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                if (cnt_q == CNT_W'(CNV_LOW_CYC - 1)) begin
                    state_d = ST_WAIT_BUSY;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_BUSY: begin
                // BUSY is not trusted until sync latency and tCNVST-to-BUSY have elapsed
                if (!armed_q) begin
                    if (cnt_q == CNT_W'(BUSY_IGNORE_CYC - 1)) begin
                        armed_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (busy_s == '0) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    adc_d   = '0;
                end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
                    tmo     = 1'b1;
                    state_d = ST_READ;
                    cnt_d   = '0;
                    adc_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                // per ADC: RD_CYC strobe cycles, one write cycle, one turnaround cycle
                if (cnt_q == CNT_W'(RD_CYC + 1)) begin
                    cnt_d = '0;
                    if (adc_q == ADC_W'(N_ADC - 1)) begin
                        state_d = ST_NEXT;
                    end else begin
                        adc_d = adc_q + ADC_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                cnt_d = '0;
                if (mux_sel == CH_W'(N_CH - 1)) begin
                    if (cont_en) begin
                        state_d = ST_SETTLE;
                        ch_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SETTLE;
                    ch_d    = mux_sel + CH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cnvst_n_d = (state_d == ST_CONVERT) ? '0 : '1;
        rd_n_d    = !((state_d == ST_READ) && (cnt_d < CNT_W'(RD_CYC)));
        cs_n_d    = '1;
        if (!rd_n_d) cs_n_d[adc_d] = 1'b0;

        res_we_d   = (state_q == ST_READ) && (cnt_q == CNT_W'(RD_CYC - 1));
        res_addr_d = res_we_d ? pack_addr(adc_q, mux_sel) : res_addr;
        res_data_d = res_we_d ? d : res_data;

        scan_done_d = (state_q == ST_NEXT) && (mux_sel == CH_W'(N_CH - 1));
        scan_act_d  = (state_d != ST_IDLE);

        err_d = err;
        if (clr_err) err_d = 1'b0;
        if (tmo)     err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            adc_q     <= '0;
            armed_q   <= 1'b0;
            mux_sel   <= '0;
            cnvst_n   <= '1;
            cs_n      <= '1;
            rd_n      <= 1'b1;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
            scan_act  <= 1'b0;
            scan_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adc_q     <= adc_d;
            armed_q   <= armed_d;
            mux_sel   <= ch_d;
            cnvst_n   <= cnvst_n_d;
            cs_n      <= cs_n_d;
            rd_n      <= rd_n_d;
            res_we    <= res_we_d;
            res_addr  <= res_addr_d;
            res_data  <= res_data_d;
            scan_act  <= scan_act_d;
            scan_done <= scan_done_d;
            err       <= err_d;
        end
    end

endmodule
